// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// default widths and the product width.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int unsigned MULT_WIDTH  = 32;
    localparam int unsigned MULT_CNT_W  = 6;
    localparam int unsigned MULT_PROD_W = 2 * MULT_WIDTH;
    localparam int unsigned CLA_WIDTH   = 32;

endpackage

// File: rtl/seq_mult_32_cla.sv
// Cla_32: 32-bit carry-lookahead adder built from eight 4-bit lookahead groups;
// G/P report the block-level generate/propagate of the whole word.
module Cla_32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c32,
    output logic        G,
    output logic        P
);

    logic [31:0] g, p, c;
    logic [7:0]  gg, gp;
    logic [8:0]  gc;
    logic        g_acc;

    assign g = x & y;
    assign p = x ^ y;

    always_comb begin
        c     = '0;
        gg    = '0;
        gp    = '0;
        gc    = '0;
        g_acc = 1'b0;
        gc[0] = c_in;
        for (int unsigned k = 0; k < 8; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
            gg[k]    = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k]    = &p[4*k +: 4];
            gc[k+1]  = gg[k] | (gp[k] & gc[k]);
            g_acc    = gg[k] | (gp[k] & g_acc);
        end
    end

    assign sum = p ^ c;
    assign c32 = gc[8];
    assign G   = g_acc;
    assign P   = &p;

endmodule

// File: rtl/seq_mult_32.sv
// Radix-2 shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH) using one Cla_32 add per
// iteration. Define MULT_SIGNED_EN to add the signed_op two's-complement mode.
module seq_mult_32
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CNT_W = MULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
`ifdef MULT_SIGNED_EN
    input  logic               signed_op,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    if (WIDTH != CLA_WIDTH) begin : g_width_err
        $error("seq_mult_32: WIDTH must equal the Cla_32 adder width");
    end
    if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_cnt_err
        $error("seq_mult_32: CNT_W too narrow for WIDTH iterations");
    end

    mult_state_t      state, state_nx;
    logic [WIDTH-1:0] a, p_hi, q;
    logic [CNT_W-1:0] count;
    logic             last_iter;
    logic [WIDTH-1:0] adder_y, adder_sum;
    logic             adder_cin, adder_c32, top;
    logic             unused_g, unused_p;
`ifdef MULT_SIGNED_EN
    logic             sgn;
`endif

    assign last_iter = (count == CNT_W'(WIDTH - 1));

    // Signed mode sign-extends the partial sum to 33 bits and turns the final
    // (sign-weight) iteration into a subtract of the multiplicand.
    always_comb begin
        adder_y   = q[0] ? a : '0;
        adder_cin = 1'b0;
        top       = adder_c32;
`ifdef MULT_SIGNED_EN
        if (sgn) begin
            if (last_iter && q[0]) begin
                adder_y   = ~a;
                adder_cin = 1'b1;
            end
            top = p_hi[WIDTH-1] ^ adder_y[WIDTH-1] ^ adder_c32;
        end
`endif
    end

    Cla_32 u_cla (
        .x    (p_hi),
        .y    (adder_y),
        .c_in (adder_cin),
        .sum  (adder_sum),
        .c32  (adder_c32),
        .G    (unused_g),
        .P    (unused_p)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_iter) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a       <= '0;
            p_hi    <= '0;
            q       <= '0;
            count   <= '0;
            product <= '0;
`ifdef MULT_SIGNED_EN
            sgn     <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        a     <= multiplicand;
                        q     <= multiplier;
                        p_hi  <= '0;
                        count <= '0;
`ifdef MULT_SIGNED_EN
                        sgn   <= signed_op;
`endif
                    end
                end
                RUN: begin
                    {p_hi, q} <= {top, adder_sum, q[WIDTH-1:1]};
                    count     <= count + 1'b1;
                    if (last_iter)
                        product <= {top, adder_sum, q[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_mult_32.sv
// Randomized self-checking bench for seq_mult_32 against an arithmetic product model.
module tb_seq_mult_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] mcand, mplier;
    logic        sgn;
    logic        busy, done;
    logic [63:0] product;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [63:0] last_prod;

    always #5 clk = ~clk;

    seq_mult_32 dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (mcand),
        .multiplier   (mplier),
`ifdef MULT_SIGNED_EN
        .signed_op    (sgn),
`endif
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Called on the negedge right after the accepting edge; done is due 32 edges later.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd32);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input string tag);
        logic [63:0] exp;
`ifndef MULT_SIGNED_EN
        s = 1'b0;
`endif
        exp = ref_mul(a, b, s);
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        sgn    = s;
        @(negedge clk);
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
        sgn    = 1'($urandom_range(0, 1));
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_hold"}, product, last_prod);
        wait_done(tag);
        check({tag, "_prod"}, product, exp);
        last_prod = exp;
        @(negedge clk);
        check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0; sgn = 1'b0;
        last_prod = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_prod", product, 64'd0);
        rst = 1'b0;

        run_op(32'd3, 32'd5, 1'b0, "basic");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "ones");
        run_op(32'd0, 32'h1234_5678, 1'b0, "zero");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("zero_hold", product, 64'd0);
            check("zero_nodone", 64'(done), 64'd0);
        end

        // start held high: the second run takes the operands present at the IDLE cycle
        @(negedge clk);
        start = 1'b1; mcand = 32'd7; mplier = 32'd9; sgn = 1'b0;
        @(negedge clk);
        mcand = 32'd2; mplier = 32'd2;
        check("b2b_busy1", 64'(busy), 64'd1);
        wait_done("b2b1");
        check("b2b1_prod", product, 64'd63);
        @(negedge clk);
        check("b2b_gap", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy2", 64'(busy), 64'd1);
        check("b2b_hold", product, 64'd63);
        wait_done("b2b2");
        check("b2b2_prod", product, 64'd4);
        last_prod = 64'd4;
        @(negedge clk);
        check("b2b_idle", {62'd0, busy, done}, 64'd0);

        // reset in the middle of a run
        @(negedge clk);
        start = 1'b1; mcand = 32'd1234; mplier = 32'd5678;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_prod", product, 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("mrst_nodone", 64'(dones), 64'd0);
        last_prod = '0;
        run_op(32'd1234, 32'd5678, 1'b0, "after_rst");
        check("after_rst_val", last_prod, 64'd7006652);

`ifdef MULT_SIGNED_EN
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, "s_neg_pos");
        run_op(32'd5, 32'hFFFF_FFFD, 1'b1, "s_pos_neg");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "s_min_min");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, "u_min_min");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "s_m1_m1");
`endif

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) ra = 32'hFFFF_FFFF;
            if (i % 8 == 1) rb = 32'h8000_0000;
            run_op(ra, rb, 1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
